lcd_line_buffer: RTL



---
 rtl/lcd_line_buffer_pkg.sv | 12 +
 rtl/lcd_line_ram.sv | 24 ++
 rtl/lcd_line_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lcd_line_buffer_pkg.sv
// Shared types and constants for the double-banked LCD line buffer.
// The default line width matches the display's active pixels per line.
package lcd_line_buffer_pkg;
    localparam int H_DISP_DEFAULT = 800;
    localparam int XPOS_W = 11;
    localparam int CNT_W  = 16;

    typedef logic [23:0] pixel_t;

    localparam pixel_t           BLACK   = 24'h000000;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/lcd_line_ram.sv
// One line bank: a single write port and a registered read port.
module lcd_line_ram
    import lcd_line_buffer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  pixel_t            wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output pixel_t            rdata
);
    pixel_t mem [DEPTH];

    // NOTE: the array and its read register are deliberately left unreset; the
    // parent's valid flags decide when their contents mean anything.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/lcd_line_buffer.sv
// Ping-pong line buffer between a pixel stream and the LCD timing driver.
// The writer fills one bank while the other is displayed; banks swap only between lines.
module lcd_line_buffer
    import lcd_line_buffer_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEFAULT,
    parameter int ADDR_W = $clog2(H_DISP)
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  pixel_t            in_data,
    input  logic              in_sof,
    input  logic              lcd_request,
    input  logic [XPOS_W-1:0] lcd_xpos,
    output pixel_t            lcd_data,
    output logic              underrun,
    output logic              sof_err,
    output logic [CNT_W-1:0]  underrun_cnt
);
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    typedef enum logic [1:0] {SYNC = ST_SYNC, FILL = ST_FILL, FULL = ST_FULL} wr_state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISP - 1);
    localparam logic [XPOS_W-1:0] LAST_XPOS = XPOS_W'(H_DISP - 1);
    localparam logic [XPOS_W-1:0] XPOS_LIM  = XPOS_W'(H_DISP);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_full_q, wr_full_d;
    logic              rd_bank_q, rd_bank_d;
    logic              rd_empty_q, rd_empty_d;
    logic              req_q, req_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_sel_q, rd_sel_d;
    logic              underrun_q, underrun_d;
    logic              sof_err_q, sof_err_d;
    logic [CNT_W-1:0]  underrun_cnt_q, underrun_cnt_d;

    logic              wr_en, rd_en, swap;
    logic [ADDR_W-1:0] wr_ptr;
    pixel_t            bank_rdata [2];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no branch can infer a latch.
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        wr_full_d      = wr_full_q;
        rd_bank_d      = rd_bank_q;
        rd_empty_d     = rd_empty_q;
        sof_err_d      = 1'b0;
        wr_en          = 1'b0;
        wr_ptr         = wr_addr_q;
        underrun_cnt_d = underrun_cnt_q;

        swap = !lcd_request && rd_empty_q && wr_full_q;

        unique case (state_q)
            SYNC: begin
                if (in_valid && in_sof) begin
                    wr_en     = 1'b1;
                    wr_ptr    = '0;
                    wr_addr_d = ADDR_W'(1);
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_sof && wr_addr_q != '0) begin
                        // A frame start mid-line resynchronises the bank onto the new frame.
                        sof_err_d = 1'b1;
                        wr_ptr    = '0;
                        wr_addr_d = ADDR_W'(1);
                    end else if (wr_addr_q == LAST_ADDR) begin
                        wr_full_d = 1'b1;
                        state_d   = FULL;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            FULL: begin
                if (swap) begin
                    wr_addr_d = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = SYNC;
        endcase

        if (swap) begin
            rd_bank_d  = ~rd_bank_q;
            rd_empty_d = 1'b0;
            wr_full_d  = 1'b0;
        end
        if (lcd_request && lcd_xpos == LAST_XPOS) rd_empty_d = 1'b1;

        rd_en      = lcd_request && !rd_empty_q && (lcd_xpos < XPOS_LIM);
        rd_vld_d   = rd_en;
        rd_sel_d   = rd_bank_q;
        req_d      = lcd_request;
        underrun_d = lcd_request && !req_q && rd_empty_q;
        if (underrun_d && underrun_cnt_q != CNT_MAX) underrun_cnt_d = underrun_cnt_q + 16'd1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q        <= SYNC;
            wr_addr_q      <= '0;
            wr_full_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            rd_empty_q     <= 1'b1;
            req_q          <= 1'b0;
            rd_vld_q       <= 1'b0;
            rd_sel_q       <= 1'b0;
            underrun_q     <= 1'b0;
            sof_err_q      <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop takes its pre-edge _d value regardless of order.
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            wr_full_q      <= wr_full_d;
            rd_bank_q      <= rd_bank_d;
            rd_empty_q     <= rd_empty_d;
            req_q          <= req_d;
            rd_vld_q       <= rd_vld_d;
            rd_sel_q       <= rd_sel_d;
            underrun_q     <= underrun_d;
            sof_err_q      <= sof_err_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    // Writes always target the bank not on display, so a read and write never collide.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        lcd_line_ram #(.DEPTH(H_DISP), .ADDR_W(ADDR_W)) u_ram (
            .clk   (iCLK),
            .we    (wr_en && (rd_bank_q != 1'(b))),
            .waddr (wr_ptr),
            .wdata (in_data),
            .re    (rd_en && (rd_bank_q == 1'(b))),
            .raddr (lcd_xpos[ADDR_W-1:0]),
            .rdata (bank_rdata[b])
        );
    end

    assign in_ready     = iRST_N && (state_q != FULL);
    assign lcd_data     = rd_vld_q ? bank_rdata[rd_sel_q] : BLACK;
    assign underrun     = underrun_q;
    assign sof_err      = sof_err_q;
    assign underrun_cnt = underrun_cnt_q;
endmodule
